// File: rtl/diff_freq_serial_tx.sv
// Multi-rate serial transmitter: each bit's duration is chosen per bit from two programmable periods.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit (low-frequency period) to every frame.
module diff_freq_serial_tx #(
   parameter int DATA_BIT     = 32,
   parameter int CNT_WIDTH    = 16,
   parameter int REPEAT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic [DATA_BIT-1:0]     i_data,
   input  logic [DATA_BIT-1:0]     i_freq_sel,
   input  logic [CNT_WIDTH-1:0]    i_period_h,
   input  logic [CNT_WIDTH-1:0]    i_period_l,
   input  logic [REPEAT_WIDTH-1:0] i_repeat,
   input  logic                    i_msb_first,
   input  logic                    i_idle_level,
   output logic                    o_data,
   output logic                    o_busy,
   output logic                    o_bit_tick,
   output logic                    o_frame_tick,
   output logic                    o_done_tick
);
   localparam int IDXW = $clog2(DATA_BIT);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BIT - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                  r_state, w_stateNext;
   logic [DATA_BIT-1:0]     r_shData, r_shFreq;
   logic [CNT_WIDTH-1:0]    r_shPerH, r_shPerL, r_cnt, w_cntNext, w_period;
   logic [REPEAT_WIDTH-1:0] r_repeat, r_frameCnt, w_frameNext, w_frameInc;
   logic [IDXW-1:0]         r_idx, w_idxNext, w_pos, w_idxInc;
   logic                    r_shMsb, r_idle, r_data, r_done;
   logic                    w_load, w_dataNext, w_doneNext, w_bitTick, w_frameTick;
   logic                    w_lastBit, w_firstBit;
`ifdef SERIAL_TX_PARITY_EN
   logic                    r_par, w_parNext;
`endif

   // Physical bit position of a logical bit index, honouring the shadowed bit order.
   function automatic logic [IDXW-1:0] posOf(input logic msb, input logic [IDXW-1:0] idx);
      return msb ? (LAST_IDX - idx) : idx;
   endfunction

   assign w_pos      = posOf(r_shMsb, r_idx);
   assign w_idxInc   = r_idx + IDXW'(1);
   assign w_frameInc = r_frameCnt + REPEAT_WIDTH'(1);
   assign w_firstBit = i_msb_first ? i_data[DATA_BIT-1] : i_data[0];
`ifdef SERIAL_TX_PARITY_EN
   assign w_period   = r_par ? r_shPerL : (r_shFreq[w_pos] ? r_shPerH : r_shPerL);
   assign w_lastBit  = r_par;
`else
   assign w_period   = r_shFreq[w_pos] ? r_shPerH : r_shPerL;
   assign w_lastBit  = (r_idx == LAST_IDX);
`endif

   // Next-state logic; o_data is registered, so w_dataNext is the level shown next cycle.
   always_comb begin
      w_stateNext = r_state;
      w_load      = 1'b0;
      w_dataNext  = r_data;
      w_cntNext   = r_cnt;
      w_idxNext   = r_idx;
      w_frameNext = r_frameCnt;
      w_doneNext  = 1'b0;
      w_bitTick   = 1'b0;
      w_frameTick = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      w_parNext   = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            w_load      = 1'b1;
            w_dataNext  = i_idle_level;
            w_cntNext   = '0;
            w_idxNext   = '0;
            w_frameNext = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_parNext   = 1'b0;
`endif
            if (i_start && !i_stop) begin
               w_stateNext = S_RUN;
               w_dataNext  = w_firstBit;
            end
         end
         S_RUN: begin
            if (i_stop) begin
               w_stateNext = S_IDLE;
               w_dataNext  = r_idle;
               w_cntNext   = '0;
               w_idxNext   = '0;
`ifdef SERIAL_TX_PARITY_EN
               w_parNext   = 1'b0;
`endif
            end else if (r_cnt == w_period) begin
               w_bitTick = 1'b1;
               w_cntNext = '0;
               if (w_lastBit) begin
                  w_frameTick = 1'b1;
                  w_frameNext = w_frameInc;
                  w_idxNext   = '0;
`ifdef SERIAL_TX_PARITY_EN
                  w_parNext   = 1'b0;
`endif
                  // A zero repeat count never matches, giving continuous operation.
                  if ((r_repeat != '0) && (w_frameInc == r_repeat)) begin
                     w_stateNext = S_IDLE;
                     w_dataNext  = r_idle;
                     w_doneNext  = 1'b1;
                  end else begin
                     w_load     = 1'b1;
                     w_dataNext = w_firstBit;
                  end
               end
`ifdef SERIAL_TX_PARITY_EN
               else if (r_idx == LAST_IDX) begin
                  w_parNext  = 1'b1;
                  w_dataNext = ^r_shData;
               end
`endif
               else begin
                  w_idxNext  = w_idxInc;
                  w_dataNext = r_shData[posOf(r_shMsb, w_idxInc)];
               end
            end else begin
               w_cntNext = r_cnt + CNT_WIDTH'(1);
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // State, counters and shadow registers; shadows reload in idle and at continuing frame ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_data     <= 1'b0;
         r_done     <= 1'b0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_frameCnt <= '0;
         r_shData   <= '0;
         r_shFreq   <= '0;
         r_shPerH   <= '0;
         r_shPerL   <= '0;
         r_shMsb    <= 1'b0;
         r_repeat   <= '0;
         r_idle     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else begin
         r_state    <= w_stateNext;
         r_data     <= w_dataNext;
         r_done     <= w_doneNext;
         r_cnt      <= w_cntNext;
         r_idx      <= w_idxNext;
         r_frameCnt <= w_frameNext;
`ifdef SERIAL_TX_PARITY_EN
         r_par      <= w_parNext;
`endif
         if (w_load) begin
            r_shData <= i_data;
            r_shFreq <= i_freq_sel;
            r_shPerH <= i_period_h;
            r_shPerL <= i_period_l;
            r_shMsb  <= i_msb_first;
         end
         if (r_state == S_IDLE) begin
            r_repeat <= i_repeat;
            r_idle   <= i_idle_level;
         end
      end
   end

   assign o_data       = r_data;
   assign o_busy       = (r_state == S_RUN);
   assign o_bit_tick   = w_bitTick;
   assign o_frame_tick = w_frameTick;
   assign o_done_tick  = r_done;
endmodule

// File: tb/tb_diff_freq_serial_tx.sv
// Directed self-checking bench for diff_freq_serial_tx (DATA_BIT=8), with a per-cycle frame model.
// Honours SERIAL_TX_PARITY_EN when the design is built with the parity bit.
module tb_diff_freq_serial_tx;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic        clk, rst_n, i_start, i_stop, i_msb_first, i_idle_level;
   logic [7:0]  i_data, i_freq_sel, i_repeat;
   logic [15:0] i_period_h, i_period_l;
   logic        o_data, o_busy, o_bit_tick, o_frame_tick, o_done_tick;

   int testsRun = 0;
   int testsFailed = 0;
   int bitTickCnt = 0;
   int frameTickCnt = 0;
   int doneTickCnt = 0;
   int snapBit, snapFrame, snapDone;

   diff_freq_serial_tx #(.DATA_BIT(8), .CNT_WIDTH(16), .REPEAT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
      .i_data(i_data), .i_freq_sel(i_freq_sel), .i_period_h(i_period_h),
      .i_period_l(i_period_l), .i_repeat(i_repeat), .i_msb_first(i_msb_first),
      .i_idle_level(i_idle_level), .o_data(o_data), .o_busy(o_busy),
      .o_bit_tick(o_bit_tick), .o_frame_tick(o_frame_tick), .o_done_tick(o_done_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (o_bit_tick)   bitTickCnt   <= bitTickCnt + 1;
      if (o_frame_tick) frameTickCnt <= frameTickCnt + 1;
      if (o_done_tick)  doneTickCnt  <= doneTickCnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic [7:0] fs, input logic [15:0] ph,
                                input logic [15:0] pl, input logic [7:0] rep, input logic msb,
                                input logic idle);
      i_data = d; i_freq_sel = fs; i_period_h = ph; i_period_l = pl;
      i_repeat = rep; i_msb_first = msb; i_idle_level = idle;
   endtask

   task automatic pulseStart();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Checks nBits bits of a frame cycle by cycle, starting at the cycle showing the first bit.
   task automatic expectFrame(input string name, input logic [7:0] d, input logic [7:0] fs,
                              input logic [15:0] ph, input logic [15:0] pl, input logic msb,
                              input int nBits);
      int pos, dur;
      for (int i = 0; i < nBits; i++) begin
         pos = msb ? 7 - i : i;
         dur = fs[pos] ? int'(ph) + 1 : int'(pl) + 1;
         for (int c = 0; c < dur; c++) begin
            checkOutput($sformatf("%s b%0d c%0d data", name, i, c), 64'(o_data), 64'(d[pos]));
            checkOutput($sformatf("%s b%0d c%0d busy", name, i, c), 64'(o_busy), 64'(1));
            checkOutput($sformatf("%s b%0d c%0d bitTick", name, i, c), 64'(o_bit_tick), 64'(c == dur - 1));
            checkOutput($sformatf("%s b%0d c%0d frameTick", name, i, c), 64'(o_frame_tick),
                        64'(c == dur - 1 && i == 7 && PAR_BITS == 0));
            checkOutput($sformatf("%s b%0d c%0d done", name, i, c), 64'(o_done_tick), 64'(0));
            @(negedge clk);
         end
      end
`ifdef SERIAL_TX_PARITY_EN
      if (nBits == 8) begin
         for (int c = 0; c <= int'(pl); c++) begin
            checkOutput($sformatf("%s par c%0d data", name, c), 64'(o_data), 64'(^d));
            checkOutput($sformatf("%s par c%0d bitTick", name, c), 64'(o_bit_tick), 64'(c == int'(pl)));
            checkOutput($sformatf("%s par c%0d frameTick", name, c), 64'(o_frame_tick), 64'(c == int'(pl)));
            @(negedge clk);
         end
      end
`endif
   endtask

   task automatic expectDone(input string name, input logic idle);
      checkOutput({name, " done"}, 64'(o_done_tick), 64'(1));
      checkOutput({name, " busyLow"}, 64'(o_busy), 64'(0));
      checkOutput({name, " idleData"}, 64'(o_data), 64'(idle));
      checkOutput({name, " noFrameTick"}, 64'(o_frame_tick), 64'(0));
      @(negedge clk);
      checkOutput({name, " doneOneCycle"}, 64'(o_done_tick), 64'(0));
   endtask

   task automatic runTest1(input string name);
      applyStimulus(8'hA5, 8'h00, 16'd0, 16'd3, 8'd1, 1'b0, 1'b0);
      pulseStart();
      expectFrame(name, 8'hA5, 8'h00, 16'd0, 16'd3, 1'b0, 8);
      expectDone(name, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
      applyStimulus(8'h00, 8'h00, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
      #2;
      checkOutput("reset data", 64'(o_data), 64'(0));
      checkOutput("reset busy", 64'(o_busy), 64'(0));
      checkOutput("reset bitTick", 64'(o_bit_tick), 64'(0));
      checkOutput("reset frameTick", 64'(o_frame_tick), 64'(0));
      checkOutput("reset done", 64'(o_done_tick), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post-reset busy", 64'(o_busy), 64'(0));

      // Test 1: A5, LSB-first, 4 cycles per bit, single frame
      runTest1("t1");

      // Test 2: mixed periods, bits 0-3 last 3 cycles and bits 4-7 one cycle
      applyStimulus(8'hFF, 8'hF0, 16'd0, 16'd2, 8'd1, 1'b0, 1'b0);
      snapBit = bitTickCnt;
      pulseStart();
      expectFrame("t2", 8'hFF, 8'hF0, 16'd0, 16'd2, 1'b0, 8);
      expectDone("t2", 1'b0);
      checkOutput("t2 bitTickCount", 64'(bitTickCnt - snapBit), 64'(8 + PAR_BITS));

      // Test 3: three frames, data changed mid-frame 1
      applyStimulus(8'hA5, 8'h00, 16'd0, 16'd1, 8'd3, 1'b0, 1'b0);
      snapFrame = frameTickCnt; snapDone = doneTickCnt;
      pulseStart();
      i_data = 8'h3C;
      expectFrame("t3f1", 8'hA5, 8'h00, 16'd0, 16'd1, 1'b0, 8);
      expectFrame("t3f2", 8'h3C, 8'h00, 16'd0, 16'd1, 1'b0, 8);
      expectFrame("t3f3", 8'h3C, 8'h00, 16'd0, 16'd1, 1'b0, 8);
      expectDone("t3", 1'b0);
      checkOutput("t3 frameTickCount", 64'(frameTickCnt - snapFrame), 64'(3));
      checkOutput("t3 doneTickCount", 64'(doneTickCnt - snapDone), 64'(1));

      // Test 4: continuous, idle high, start ignored while busy, stop during bit 5 of frame 4
      applyStimulus(8'h5A, 8'h00, 16'd0, 16'd0, 8'd0, 1'b0, 1'b1);
      snapDone = doneTickCnt;
      pulseStart();
      expectFrame("t4f1", 8'h5A, 8'h00, 16'd0, 16'd0, 1'b0, 8);
      i_start = 1'b1;
      expectFrame("t4f2", 8'h5A, 8'h00, 16'd0, 16'd0, 1'b0, 8);
      i_start = 1'b0;
      expectFrame("t4f3", 8'h5A, 8'h00, 16'd0, 16'd0, 1'b0, 8);
      expectFrame("t4f4", 8'h5A, 8'h00, 16'd0, 16'd0, 1'b0, 5);
      checkOutput("t4 bit5 data", 64'(o_data), 64'(0));
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
      checkOutput("t4 stop data", 64'(o_data), 64'(1));
      checkOutput("t4 stop busy", 64'(o_busy), 64'(0));
      checkOutput("t4 stop done", 64'(o_done_tick), 64'(0));
      checkOutput("t4 stop bitTick", 64'(o_bit_tick), 64'(0));
      checkOutput("t4 stop frameTick", 64'(o_frame_tick), 64'(0));
      @(negedge clk);
      checkOutput("t4 idle data", 64'(o_data), 64'(1));
      checkOutput("t4 doneTickCount", 64'(doneTickCnt - snapDone), 64'(0));

      // Test 5: start+stop together in idle, then MSB-first 01
      applyStimulus(8'h01, 8'h00, 16'd0, 16'd1, 8'd1, 1'b1, 1'b0);
      @(negedge clk);
      i_start = 1'b1; i_stop = 1'b1;
      @(negedge clk);
      i_start = 1'b0; i_stop = 1'b0;
      checkOutput("t5 startStop busy", 64'(o_busy), 64'(0));
      checkOutput("t5 startStop data", 64'(o_data), 64'(0));
      @(negedge clk);
      checkOutput("t5 still idle", 64'(o_busy), 64'(0));
      pulseStart();
      expectFrame("t5", 8'h01, 8'h00, 16'd0, 16'd1, 1'b1, 8);
      expectDone("t5", 1'b0);

      // Test 6: asynchronous reset mid-frame, then a fresh test-1 transfer
      applyStimulus(8'hA5, 8'h00, 16'd0, 16'd3, 8'd1, 1'b0, 1'b0);
      pulseStart();
      expectFrame("t6pre", 8'hA5, 8'h00, 16'd0, 16'd3, 1'b0, 2);
      checkOutput("t6 bit2 data", 64'(o_data), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6 rst data", 64'(o_data), 64'(0));
      checkOutput("t6 rst busy", 64'(o_busy), 64'(0));
      checkOutput("t6 rst bitTick", 64'(o_bit_tick), 64'(0));
      checkOutput("t6 rst frameTick", 64'(o_frame_tick), 64'(0));
      checkOutput("t6 rst done", 64'(o_done_tick), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t6 post busy", 64'(o_busy), 64'(0));
      runTest1("t6");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
